// File: rtl/apb_req_arbiter.sv
// Round-robin (or fixed priority with ARB_FIXED_PRIO_EN) sharing of one APB master port; 3 cycles psel->pready when the slave is ready at once.
// Losers hold psel until served; stalled ACCESS phases abort after TIMEOUT_CYC cycles with pslverr and prdata=16'hFFFF.
module apb_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_REQ*32-1:0]   s_paddr,
  input  logic [NUM_REQ-1:0]      s_pwrite,
  input  logic [NUM_REQ-1:0]      s_psel,
  input  logic [NUM_REQ-1:0]      s_penable,
  input  logic [NUM_REQ*16-1:0]   s_pwdata,
  output logic [NUM_REQ-1:0]      s_pready,
  output logic [15:0]             s_prdata,
  output logic [NUM_REQ-1:0]      s_pslverr,
  output logic [31:0]             m_paddr,
  output logic                    m_pwrite,
  output logic                    m_psel,
  output logic                    m_penable,
  output logic [15:0]             m_pwdata,
  input  logic                    m_pready,
  input  logic [15:0]             m_prdata,
  input  logic                    m_pslverr,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    timeout_pulse
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;

  // Requesters drive penable for their own APB handshake only; arbitration keys on psel.
  logic unused_penable;
  assign unused_penable = ^s_penable;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_psel[k]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g_idx;
  int               cand;

  // Search starts at rr_ptr and wraps, so the last owner is checked last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_vld && s_psel[IDX_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      m_paddr       <= '0;
      m_pwrite      <= 1'b0;
      m_psel        <= 1'b0;
      m_penable     <= 1'b0;
      m_pwdata      <= '0;
      s_pready      <= '0;
      s_pslverr     <= '0;
      s_prdata      <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr        <= '0;
      g_idx         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= SETUP;
            busy     <= 1'b1;
            grant    <= NUM_REQ'(1) << win_idx;
            m_psel   <= 1'b1;
            m_paddr  <= s_paddr[win_idx*32 +: 32];
            m_pwrite <= s_pwrite[win_idx];
            m_pwdata <= s_pwdata[win_idx*16 +: 16];
`ifndef ARB_FIXED_PRIO_EN
            g_idx    <= win_idx;
`endif
          end
        end
        SETUP: begin
          state     <= ACCESS;
          m_penable <= 1'b1;
          tmo_cnt   <= '0;
        end
        ACCESS: begin
          if (m_pready || tmo_hit) begin
            state     <= RESP;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_paddr   <= '0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
            s_pready  <= grant;
            // A response arriving on the last allowed cycle still counts as a normal completion.
            if (m_pready) begin
              s_prdata  <= m_prdata;
              s_pslverr <= grant & {NUM_REQ{m_pslverr}};
            end else begin
              s_prdata      <= 16'hFFFF;
              s_pslverr     <= grant;
              timeout_pulse <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          state         <= IDLE;
          s_pready      <= '0;
          s_pslverr     <= '0;
          s_prdata      <= '0;
          timeout_pulse <= 1'b0;
          grant         <= '0;
          busy          <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr        <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: latency, arbitration order, timeout, slave error, async reset.
module tb_apb_req_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N*32-1:0] s_paddr = '0;
  logic [N-1:0]    s_pwrite = '0;
  logic [N-1:0]    s_psel = '0;
  logic [N-1:0]    s_penable = '0;
  logic [N*16-1:0] s_pwdata = '0;
  logic [N-1:0]    s_pready;
  logic [15:0]     s_prdata;
  logic [N-1:0]    s_pslverr;
  logic [31:0]     m_paddr;
  logic            m_pwrite;
  logic            m_psel;
  logic            m_penable;
  logic [15:0]     m_pwdata;
  logic            m_pready;
  logic [15:0]     m_prdata;
  logic            m_pslverr;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_pulse;

  logic            slv_stall = 1'b0;
  logic            slv_err = 1'b0;
  logic [15:0]     slv_rdata = '0;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Slave answers in the first ACCESS cycle unless stalled.
  assign m_pready  = m_psel & m_penable & ~slv_stall;
  assign m_prdata  = slv_rdata;
  assign m_pslverr = slv_err;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(256), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwdata(s_pwdata), .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwdata(m_pwdata), .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_setup(input int limit);
    int c = 0;
    while (!(m_psel && !m_penable) && c < limit) begin
      step();
      c++;
    end
    check("setup_seen", m_psel && !m_penable, 1);
  endtask

  task automatic wait_access(input int limit);
    int c = 0;
    while (!m_penable && c < limit) begin
      step();
      c++;
    end
    check("access_seen", m_penable, 1);
  endtask

  task automatic wait_pready(input int limit);
    int c = 0;
    while (s_pready == 0 && c < limit) begin
      step();
      c++;
    end
    check("pready_seen", s_pready != 0, 1);
  endtask

  initial begin
    int n;
    int last_cyc;
    int exp_g;
    int seen;

    // Reset state
    #12;
    check("rst_m_psel", m_psel, 0);
    check("rst_m_penable", m_penable, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_s_pready", s_pready, 0);
    check("rst_m_paddr", m_paddr, 0);
    check("rst_tmo", timeout_pulse, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // Single read from req0: SETUP, ACCESS, then RESP three edges after the IDLE sample
    s_paddr[31:0] = 32'h0001_0004;
    s_pwrite = 2'b00;
    slv_rdata = 16'hA5A5;
    s_psel = 2'b01;
    step();
    check("t1_setup_psel", m_psel, 1);
    check("t1_setup_penable", m_penable, 0);
    check("t1_setup_paddr", m_paddr, 32'h0001_0004);
    check("t1_setup_grant", grant, 2'b01);
    check("t1_setup_busy", busy, 1);
    step();
    check("t1_access_penable", m_penable, 1);
    check("t1_access_pready", s_pready, 0);
    step();
    check("t1_resp_pready", s_pready, 2'b01);
    check("t1_resp_prdata", s_prdata, 16'hA5A5);
    check("t1_resp_pslverr", s_pslverr, 0);
    check("t1_resp_m_psel", m_psel, 0);
    check("t1_resp_m_paddr", m_paddr, 0);
    s_psel = 2'b00;
    step();
    check("t1_idle_pready", s_pready, 0);
    check("t1_idle_grant", grant, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_prdata", s_prdata, 0);

    // Both requesters writing continuously from reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    s_pwdata = {16'h5678, 16'h1234};
    s_pwrite = 2'b11;
    s_psel = 2'b11;
    last_cyc = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 2;
`endif
      wait_setup(10);
      check($sformatf("t2_grant_%0d", k), grant, N'(1) << exp_g);
      check($sformatf("t2_pwdata_%0d", k), m_pwdata, (exp_g == 1) ? 16'h5678 : 16'h1234);
      check($sformatf("t2_pwrite_%0d", k), m_pwrite, 1);
      wait_pready(10);
      check($sformatf("t2_pready_%0d", k), s_pready, N'(1) << exp_g);
      if (k > 0) check($sformatf("t2_period_%0d", k), cyc_cnt - last_cyc, 4);
      last_cyc = cyc_cnt;
      step();
    end
    s_psel = 2'b10;
    wait_setup(10);
    check("t2_req1_grant", grant, 2'b10);
    wait_pready(10);
    check("t2_req1_pready", s_pready, 2'b10);
    s_psel = 2'b00;
    step();

    // Stalled slave aborts after 256 ACCESS cycles
    slv_stall = 1'b1;
    s_pwrite = 2'b00;
    s_psel = 2'b01;
    wait_access(10);
    n = 0;
    while (m_penable && n < 400) begin
      n++;
      step();
    end
    check("t3_access_cycles", n, 256);
    check("t3_tmo_pulse", timeout_pulse, 1);
    check("t3_pready", s_pready, 2'b01);
    check("t3_prdata", s_prdata, 16'hFFFF);
    check("t3_pslverr", s_pslverr, 2'b01);
    check("t3_m_psel", m_psel, 0);
    s_psel = 2'b00;
    slv_stall = 1'b0;
    step();
    check("t3_tmo_cleared", timeout_pulse, 0);
    s_pwdata[31:16] = 16'hBEEF;
    s_pwrite = 2'b10;
    s_psel = 2'b10;
    wait_pready(10);
    check("t3_next_pready", s_pready, 2'b10);
    check("t3_next_pslverr", s_pslverr, 0);
    check("t3_next_tmo", timeout_pulse, 0);
    s_psel = 2'b00;
    step();

    // Slave error on a write reaches only the granted requester, for one cycle
    slv_err = 1'b1;
    s_psel = 2'b10;
    wait_access(10);
    check("t4_access_pslverr", s_pslverr, 0);
    step();
    check("t4_resp_pslverr", s_pslverr, 2'b10);
    check("t4_resp_pready", s_pready, 2'b10);
    s_psel = 2'b00;
    slv_err = 1'b0;
    step();
    check("t4_after_pslverr", s_pslverr, 0);

    // Asynchronous reset in the middle of an ACCESS phase
    slv_stall = 1'b1;
    s_pwrite = 2'b00;
    s_psel = 2'b01;
    wait_access(10);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_m_psel", m_psel, 0);
    check("t5_rst_m_penable", m_penable, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    s_psel = 2'b00;
    slv_stall = 1'b0;
    step();
    step();
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (s_pready != 0) seen++;
    end
    check("t5_no_pready", seen, 0);
    s_psel = 2'b10;
    step();
    check("t5_req1_grant", grant, 2'b10);
    wait_pready(10);
    check("t5_req1_pready", s_pready, 2'b10);
    s_psel = 2'b00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
